// File: rtl/systolic_skew_buffer.sv
// Systolic skew buffer: accepts one N-lane row per AXI4-Stream handshake and
// staggers it so that lane i reaches the array i+1 enabled cycles after the
// accepting edge. After a tile's last row it injects N-1 bubble rows so that
// the tile fully exits before the next one starts.
module systolic_skew_buffer #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            axi_clk,
  input  logic            axi_rst_n,
  input  logic            s_axis_valid,
  input  logic [N*DW-1:0] s_axis_data,
  input  logic            s_axis_last,
  output logic            s_axis_ready,
  input  logic            array_en,
  output logic [N*DW-1:0] out_data,
  output logic [N-1:0]    out_valid,
  output logic            out_last,
  output logic            busy
);

  // The drain counter must hold N-1; keep at least one bit for N=1.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] STREAM = 1'b0;
  localparam logic [0:0] DRAIN  = 1'b1;

  logic [N*DW-1:0] rowQ   [N];
  logic [N*DW-1:0] rowD   [N];
  logic [N-1:0]    validQ;
  logic [N-1:0]    validD;
  logic [N-1:0]    lastQ;
  logic [N-1:0]    lastD;
  logic [0:0]      stateQ;
  logic [0:0]      stateD;
  logic [CW-1:0]   cntQ;
  logic [CW-1:0]   cntD;
  logic            accept;

  assign s_axis_ready = array_en & (stateQ == STREAM);
  assign accept       = s_axis_valid & s_axis_ready;

  // Next contents of the shift chain: inject the accepted row or a bubble,
  // shift everything one stage along, and hold all of it while frozen.
  always_comb begin
    rowD   = rowQ;
    validD = validQ;
    lastD  = lastQ;
    if (array_en) begin
      rowD[0]   = accept ? s_axis_data : '0;
      validD[0] = accept;
      lastD[0]  = accept & s_axis_last;
      for (int k = 1; k < N; k++) begin
        rowD[k]   = rowQ[k-1];
        validD[k] = validQ[k-1];
        lastD[k]  = lastQ[k-1];
      end
    end
  end

  // Stream/drain control: a last row blocks new input for N-1 enabled cycles.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    if (array_en) begin
      case (stateQ)
        STREAM: begin
          if (accept && s_axis_last && (N > 1)) begin
            stateD = DRAIN;
            cntD   = CW'(N - 1);
          end
        end
        DRAIN: begin
          cntD = cntQ - 1'b1;
          if (cntQ == CW'(1)) begin
            stateD = STREAM;
          end
        end
        default: begin
          stateD = STREAM;
          cntD   = '0;
        end
      endcase
    end
  end

  // State registers; reset clears the whole pipeline at once, even mid-drain.
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      for (int k = 0; k < N; k++) begin
        rowQ[k] <= '0;
      end
      validQ <= '0;
      lastQ  <= '0;
      stateQ <= STREAM;
      cntQ   <= '0;
    end else begin
      rowQ   <= rowD;
      validQ <= validD;
      lastQ  <= lastD;
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // Each lane taps its own stage, which produces the diagonal skew.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign out_data[i*DW +: DW] = rowQ[i][i*DW +: DW];
    assign out_valid[i]         = validQ[i];
  end

  assign out_last = lastQ[N-1];
  assign busy     = (stateQ == DRAIN) | (|validQ);

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Self-checking bench for systolic_skew_buffer (N=4, DW=8). A history model
// of injected rows predicts every output each cycle; directed phases add
// hand-computed literal expectations at the interesting points.
module tb_systolic_skew_buffer;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            axi_clk      = 1'b0;
  logic            axi_rst_n    = 1'b0;
  logic            s_axis_valid = 1'b0;
  logic [N*DW-1:0] s_axis_data  = '0;
  logic            s_axis_last  = 1'b0;
  logic            s_axis_ready;
  logic            array_en     = 1'b1;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_valid;
  logic            out_last;
  logic            busy;

  int compared   = 0;
  int mismatched = 0;

  systolic_skew_buffer #(.N(N), .DW(DW)) dut (
    .axi_clk      (axi_clk),
    .axi_rst_n    (axi_rst_n),
    .s_axis_valid (s_axis_valid),
    .s_axis_data  (s_axis_data),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .array_en     (array_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .busy         (busy)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct packed {
    logic [N*DW-1:0] data;
    logic            valid;
    logic            last;
  } entry_t;

  // hist[j] is the row (or bubble) injected j enabled edges before the latest one.
  entry_t hist[$];
  int     drainLeft = 0;

  logic [N*DW-1:0] expData;
  logic [N-1:0]    expValid;
  logic            expLast;
  logic            expBusy;
  logic            expReady;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic valid, input logic last,
                               input logic [N*DW-1:0] data);
    @(posedge axi_clk);
    #1;
    array_en     = en;
    s_axis_valid = valid;
    s_axis_last  = last;
    s_axis_data  = data;
  endtask

  function automatic entry_t histAt(input int j);
    entry_t e;
    e = '0;
    if (j < hist.size()) e = hist[j];
    return e;
  endfunction

  // Reference model: a row entering while input is open is seen on lane i
  // after i+1 enabled edges; a last row closes the input for N-1 enabled edges.
  always @(posedge axi_clk or negedge axi_rst_n) begin
    entry_t e;
    logic   took;
    if (!axi_rst_n) begin
      hist.delete();
      drainLeft = 0;
    end else if (array_en) begin
      took = s_axis_valid && (drainLeft == 0);
      e    = '0;
      if (took) begin
        e.data  = s_axis_data;
        e.valid = 1'b1;
        e.last  = s_axis_last;
      end
      hist.push_front(e);
      if (hist.size() > N) void'(hist.pop_back());
      if (drainLeft > 0) drainLeft = drainLeft - 1;
      else if (took && s_axis_last && (N > 1)) drainLeft = N - 1;
    end
  end

  // Every cycle, compare all outputs against the model away from the edge.
  always @(negedge axi_clk) begin
    entry_t e;
    for (int i = 0; i < N; i++) begin
      e = histAt(i);
      expData[i*DW +: DW] = e.data[i*DW +: DW];
      expValid[i]         = e.valid;
    end
    e        = histAt(N - 1);
    expLast  = e.last;
    expBusy  = (drainLeft > 0) || (|expValid);
    expReady = array_en && (drainLeft == 0);
    checkOutput("model out_data", out_data, expData);
    checkOutput("model out_valid", 32'(out_valid), 32'(expValid));
    checkOutput("model out_last", 32'(out_last), 32'(expLast));
    checkOutput("model busy", 32'(busy), 32'(expBusy));
    checkOutput("model s_axis_ready", 32'(s_axis_ready), 32'(expReady));
  end

  initial begin
    logic [7:0] b;

    // Reset with the array enabled: everything quiet, input open.
    repeat (2) @(negedge axi_clk);
    checkOutput("reset out_data", out_data, 32'h0);
    checkOutput("reset out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset out_last", 32'(out_last), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset ready", 32'(s_axis_ready), 32'h1);
    axi_rst_n = 1'b1;

    // One row walks diagonally across the lanes.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h44332211);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge axi_clk);
    checkOutput("single lane0", out_data, 32'h00000011);
    checkOutput("single valid0", 32'(out_valid), 32'h1);
    @(negedge axi_clk);
    checkOutput("single lane1", out_data, 32'h00002200);
    checkOutput("single valid1", 32'(out_valid), 32'h2);
    @(negedge axi_clk);
    checkOutput("single lane2", out_data, 32'h00330000);
    checkOutput("single valid2", 32'(out_valid), 32'h4);
    @(negedge axi_clk);
    checkOutput("single lane3", out_data, 32'h44000000);
    checkOutput("single valid3", 32'(out_valid), 32'h8);
    @(negedge axi_clk);
    checkOutput("single empty", out_data, 32'h0);
    checkOutput("single idle busy", 32'(busy), 32'h0);

    // Three-row tile: input closes for three cycles after the last row.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h13121110);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h23222120);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h33323130);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge axi_clk);
      checkOutput("drain ready low", 32'(s_axis_ready), 32'h0);
      checkOutput("drain last early", 32'(out_last), 32'h0);
    end
    @(negedge axi_clk);
    checkOutput("drain ready back", 32'(s_axis_ready), 32'h1);
    checkOutput("tile out_last", 32'(out_last), 32'h1);
    checkOutput("tile lane3", out_data, 32'h33000000);
    checkOutput("tile busy", 32'(busy), 32'h1);
    @(negedge axi_clk);
    checkOutput("tile last gone", 32'(out_last), 32'h0);
    checkOutput("tile busy falls", 32'(busy), 32'h0);

    // Freeze for two edges while the source keeps offering a row.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h04030201);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h08070605);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0C0B0A09);
    @(negedge axi_clk);
    checkOutput("freeze data a", out_data, 32'h00000205);
    checkOutput("freeze ready a", 32'(s_axis_ready), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0C0B0A09);
    @(negedge axi_clk);
    checkOutput("freeze data b", out_data, 32'h00000205);
    checkOutput("freeze valid b", 32'(out_valid), 32'h3);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0C0B0A09);
    @(negedge axi_clk);
    checkOutput("freeze held", out_data, 32'h00000205);
    checkOutput("resume ready", 32'(s_axis_ready), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge axi_clk);
    checkOutput("resume data", out_data, 32'h00030609);
    checkOutput("resume valid", 32'(out_valid), 32'h7);

    // Row A, one idle cycle, row B: a bubble separates them on every lane.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hA4A3A2A1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hB4B3B2B1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge axi_clk);
    checkOutput("gap data a", out_data, 32'h00A300B1);
    checkOutput("gap valid a", 32'(out_valid), 32'h5);
    @(negedge axi_clk);
    checkOutput("gap data b", out_data, 32'hA400B200);
    checkOutput("gap valid b", 32'(out_valid), 32'hA);

    // Reset pulse in the middle of a drain, counter at two.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h55555555);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge axi_clk);
    #2;
    axi_rst_n = 1'b0;
    #1;
    checkOutput("midreset out_data", out_data, 32'h0);
    checkOutput("midreset out_valid", 32'(out_valid), 32'h0);
    checkOutput("midreset busy", 32'(busy), 32'h0);
    checkOutput("midreset ready", 32'(s_axis_ready), 32'h1);
    #1;
    axi_rst_n = 1'b1;
    @(negedge axi_clk);
    checkOutput("postreset ready", 32'(s_axis_ready), 32'h1);
    checkOutput("postreset busy", 32'(busy), 32'h0);

    // Mixed table of enables, gaps and tile ends, offered even while draining.
    for (int i = 0; i < 120; i++) begin
      b = 8'(i);
      applyStimulus(((i % 7) != 3) && ((i % 11) != 5), (i % 3) != 1, (i % 5) == 4,
                    {b + 8'h40, b + 8'h30, b + 8'h20, b + 8'h10});
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (8) @(negedge axi_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/systolic_skew_buffer.md
SYSTOLIC_SKEW_BUFFER -- requirements
Module: systolic_skew_buffer

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of lanes, equal to the systolic array edge; legal range 1..16.
REQ-002 SHALL have parameter DW, default 8, meaning element width in bits.
REQ-003 SHALL have port axi_clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-004 SHALL have port axi_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port s_axis_valid, input, 1 bit, AXI4-S slave valid.
REQ-006 SHALL have port s_axis_data, input, N*DW bits, one row; lane i occupies bits [i*DW +: DW].
REQ-007 SHALL have port s_axis_last, input, 1 bit, marks the final row of a tile.
REQ-008 SHALL have port s_axis_ready, output, 1 bit, AXI4-S slave ready.
REQ-009 SHALL have port array_en, input, 1 bit; high advances the skew pipeline, low freezes it.
REQ-010 SHALL have port out_data, output, N*DW bits, skewed lane data to the array.
REQ-011 SHALL have port out_valid, output, N bits; bit i flags a real (non-bubble) element on lane i.
REQ-012 SHALL have port out_last, output, 1 bit; high while lane N-1 carries the tile's last row.
REQ-013 SHALL have port busy, output, 1 bit; high while in state DRAIN or while any out_valid bit is set.

Function
REQ-014 SHALL implement a shift chain of N stages, stage[0..N-1], each holding one N*DW row, one row-valid bit and one last bit.
REQ-015 SHALL, on each edge with array_en=1, load stage[0] from the input, and shift stage[k] into stage[k+1].
REQ-016 SHALL load stage[0] with s_axis_data, valid=1 and last=s_axis_last on handshake (s_axis_valid & s_axis_ready); otherwise it SHALL load data=0, valid=0, last=0 (zero bubble).
REQ-017 SHALL hold all stages, the state and the counter unchanged on every edge with array_en=0.
REQ-018 SHALL drive out_data lane i = stage[i] lane i, and out_valid[i] = stage[i].valid; this gives a fixed lane-i latency of i+1 enabled cycles from the accepting edge.
REQ-019 SHALL drive out_last = stage[N-1].last.
REQ-020 SHALL have two states, STREAM and DRAIN; reset enters STREAM.
REQ-021 SHALL drive s_axis_ready = array_en & (state==STREAM), combinationally.
REQ-022 SHALL move STREAM->DRAIN on an accepting edge with s_axis_last=1 when N>1, and load the drain counter with N-1.
REQ-023 SHALL, in DRAIN, decrement the counter on each array_en=1 edge, injecting zero bubbles; on the edge where the counter goes 1->0 it SHALL return to STREAM.
REQ-024 SHALL stay in STREAM after a last handshake when N=1.
REQ-025 SHALL ignore s_axis_data, s_axis_valid and s_axis_last whenever s_axis_ready=0; no row is lost or duplicated.
REQ-026 SHALL size the counter as clog2(N) bits, minimum 1.

Reset
REQ-027 SHALL, while axi_rst_n=0 at any time including mid-DRAIN, immediately clear all stages, the counter and the state.
REQ-028 SHALL give every output a reset value of 0 (out_data, out_valid, out_last, busy), with s_axis_ready = array_en.

Verification
REQ-029 SHALL cover: reset with array_en=1 -> all outputs 0, s_axis_ready=1.
REQ-030 SHALL cover (N=4, DW=8, array_en=1) single row 0x44332211 accepted at edge 0 -> lane0=0x11 after edge 1, lane1=0x22 after edge 2, lane2=0x33 after edge 3, lane3=0x44 after edge 4; each out_valid bit high for exactly those cycles; all other lane values 0.
REQ-031 SHALL cover three back-to-back rows with last on the third -> s_axis_ready low for exactly 3 cycles after the third accept; out_last high for 1 cycle, 4 edges after that accept; busy falls after last exits.
REQ-032 SHALL cover array_en low for 2 cycles mid-stream with s_axis_valid=1 -> outputs frozen, s_axis_ready=0, no accept; resuming gives identical sequence shifted by 2.
REQ-033 SHALL cover axi_rst_n pulsed low during DRAIN (counter=2) -> outputs 0 immediately; after release state STREAM and s_axis_ready=1.
REQ-034 SHALL cover s_axis_valid gaps (rows A, idle, B) -> zero bubble row between A and B on every lane, with the matching out_valid bits 0.
